// File: rtl/csa_pkg.sv
// Shared widths and tree-shape helpers for the 16-operand carry-save summation unit.
package csa_pkg;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned N_IN  = 16;

    typedef logic [WIDTH-1:0] word_t;

    // Operands alive at tree level lvl: each level turns every full group of three into two.
    function automatic int unsigned level_ops(input int unsigned n_in, input int unsigned lvl);
        int unsigned n;
        n = n_in;
        for (int unsigned i = 0; i < lvl; i++) begin
            n = n - n / 3;
        end
        return n;
    endfunction

    // Offset of level lvl inside the flattened tree storage.
    function automatic int unsigned level_base(input int unsigned n_in, input int unsigned lvl);
        int unsigned base;
        base = 0;
        for (int unsigned i = 0; i < lvl; i++) begin
            base = base + level_ops(n_in, i);
        end
        return base;
    endfunction

    function automatic int unsigned tree_levels(input int unsigned n_in);
        int unsigned n;
        int unsigned levels;
        n      = n_in;
        levels = 0;
        while (n > 2) begin
            n      = n - n / 3;
            levels = levels + 1;
        end
        return levels;
    endfunction

endpackage

// File: rtl/adder_64b.sv
// 64-bit Kogge-Stone prefix adder, no carry-out.
module adder_64b
    import csa_pkg::*;
(
    input  logic  cin,
    input  word_t x,
    input  word_t y,
    output word_t s
);

    word_t gg;
    word_t pp;

    // Bit k of gg ends up as the carry into bit k; cin sits in the bit-0 slot.
    always_comb begin
        gg = {x[WIDTH-2:0] & y[WIDTH-2:0], cin};
        pp = {x[WIDTH-2:0] ^ y[WIDTH-2:0], 1'b0};
        for (int unsigned d = 1; d < WIDTH; d = d * 2) begin
            gg = gg | (pp & (gg << d));
            pp = pp & (pp << d);
        end
    end

    assign s = x ^ y ^ gg;

endmodule

// File: rtl/csa_3to2.sv
// Bitwise 3:2 carry-save cell; the carry out of the top bit is dropped (mod 2^WIDTH).
module csa_3to2 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] carry
);

    assign s     = a ^ b ^ c;
    assign carry = {(a[WIDTH-2:0] & b[WIDTH-2:0]) |
                    (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                    (b[WIDTH-2:0] & c[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/csa_tree_16to2_adder.sv
// Two-stage pipelined 16-operand adder: CSA tree to a registered sum/carry pair, then prefix add.
module csa_tree_16to2_adder
    import csa_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    input  word_t augends [N_IN-1:0],
    output word_t sum,
    output logic  out_valid,
    output word_t reduced1,
    output word_t reduced2
);

    localparam int unsigned LEVELS = tree_levels(N_IN);
    localparam int unsigned TOTAL  = level_base(N_IN, LEVELS + 1);
    localparam int unsigned ROOT   = level_base(N_IN, LEVELS);

    // All tree levels stored back to back; level l starts at level_base(N_IN, l).
    word_t tree [TOTAL];
    word_t add_s;
    logic  v1;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign tree[i] = augends[i];
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned PREV = level_ops(N_IN, l - 1);
        localparam int unsigned NCSA = PREV / 3;
        localparam int unsigned SRC  = level_base(N_IN, l - 1);
        localparam int unsigned DST  = level_base(N_IN, l);

        for (genvar j = 0; j < NCSA; j++) begin : g_csa
            csa_3to2 #(
                .WIDTH(WIDTH)
            ) u_csa (
                .a    (tree[SRC + 3 * j]),
                .b    (tree[SRC + 3 * j + 1]),
                .c    (tree[SRC + 3 * j + 2]),
                .s    (tree[DST + 2 * j]),
                .carry(tree[DST + 2 * j + 1])
            );
        end

        for (genvar k = 0; k < PREV - 3 * NCSA; k++) begin : g_pass
            assign tree[DST + 2 * NCSA + k] = tree[SRC + 3 * NCSA + k];
        end
    end

    adder_64b u_add (
        .cin(1'b0),
        .x  (reduced1),
        .y  (reduced2),
        .s  (add_s)
    );

    // Data registers advance every cycle; only the valid bits carry meaning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reduced1  <= '0;
            reduced2  <= '0;
            v1        <= 1'b0;
            sum       <= '0;
            out_valid <= 1'b0;
        end else begin
            reduced1  <= tree[ROOT];
            reduced2  <= tree[ROOT + 1];
            v1        <= in_valid;
            sum       <= add_s;
            out_valid <= v1;
        end
    end

endmodule

// File: tb/tb_csa_tree_16to2_adder.sv
// Table-driven bench for csa_tree_16to2_adder: Booth vectors, wrap cases, bubbles, reset flush.
module tb_csa_tree_16to2_adder;
    import csa_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b1;
    logic  in_valid = 1'b0;
    word_t augends [N_IN-1:0];
    word_t sum;
    word_t reduced1;
    word_t reduced2;
    logic  out_valid;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit    vld;
        word_t a [N_IN];
        word_t exp;
    } vec_t;

    vec_t tbl [$];

    csa_tree_16to2_adder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .augends  (augends),
        .sum      (sum),
        .out_valid(out_valid),
        .reduced1 (reduced1),
        .reduced2 (reduced2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Radix-4 Booth partial products of m*q; expected product supplied by hand.
    function automatic vec_t booth_vec(input logic [31:0] m, input logic [31:0] q,
                                       input word_t exp);
        vec_t       v;
        logic [32:0] qx;
        logic [2:0]  t;
        longint      digit;
        longint      ms;
        qx = {q, 1'b0};
        ms = longint'($signed(m));
        for (int i = 0; i < N_IN; i++) begin
            t        = qx[2*i+2 -: 3];
            digit    = -2 * longint'(t[2]) + longint'(t[1]) + longint'(t[0]);
            v.a[i]   = word_t'(ms * digit) << (2 * i);
        end
        v.vld = 1'b1;
        v.exp = exp;
        return v;
    endfunction

    function automatic vec_t rand_vec(input bit vld);
        vec_t v;
        v.exp = '0;
        for (int i = 0; i < N_IN; i++) begin
            v.a[i] = {$urandom, $urandom};
            v.exp  = v.exp + v.a[i];
        end
        v.vld = vld;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid = v.vld;
        for (int i = 0; i < N_IN; i++) augends[i] = v.a[i];
    endtask

    initial begin
        vec_t v;
        vec_t x;
        vec_t y;
        vec_t z;
        int   n;

        for (int i = 0; i < N_IN; i++) augends[i] = '0;

        // Hand vectors
        for (int i = 0; i < N_IN; i++) v.a[i] = '0;
        v.vld = 1'b1;
        v.exp = '0;
        tbl.push_back(v);
        tbl.push_back(booth_vec(32'd15, 32'd10, 64'd150));
        tbl.push_back(booth_vec(-32'sd15, 32'd10, 64'hFFFF_FFFF_FFFF_FF6A));
        tbl.push_back(booth_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1));
        tbl.push_back(booth_vec(32'h7FFF_FFFF, 32'd1, 64'h0000_0000_7FFF_FFFF));
        tbl.push_back(booth_vec(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000));
        for (int i = 0; i < N_IN; i++) v.a[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        v.exp = 64'hFFFF_FFFF_FFFF_FFF0;
        tbl.push_back(v);
        for (int i = 0; i < N_IN; i++) v.a[i] = '0;
        v.a[0] = 64'h8000_0000_0000_0000;
        v.a[1] = 64'h8000_0000_0000_0000;
        v.exp  = '0;
        tbl.push_back(v);
        // A, B, bubble, C
        tbl.push_back(rand_vec(1'b1));
        tbl.push_back(rand_vec(1'b1));
        tbl.push_back(rand_vec(1'b0));
        tbl.push_back(rand_vec(1'b1));
        for (int i = 0; i < 8; i++) tbl.push_back(rand_vec(1'b1));
        n = tbl.size();

        // Asynchronous reset from power-up
        #1 rst_n = 1'b0;
        #1;
        check("reset sum", sum, '0);
        check("reset reduced1", reduced1, '0);
        check("reset reduced2", reduced2, '0);
        check("reset out_valid", word_t'(out_valid), '0);
        #10 rst_n = 1'b1;

        for (int c = 0; c < n + 2; c++) begin
            @(negedge clk);
            check($sformatf("out_valid[%0d]", c), word_t'(out_valid),
                  (c >= 2) ? word_t'(tbl[c-2].vld) : '0);
            if (c >= 2 && tbl[c-2].vld)
                check($sformatf("sum[%0d]", c - 2), sum, tbl[c-2].exp);
            if (c >= 1 && c - 1 < n && tbl[c-1].vld)
                check($sformatf("reduced[%0d]", c - 1), reduced1 + reduced2, tbl[c-1].exp);
            if (c < n) drive(tbl[c]);
            else in_valid = 1'b0;
        end

        // Reset with two sets in flight
        x = rand_vec(1'b1);
        y = rand_vec(1'b1);
        z = rand_vec(1'b1);
        @(negedge clk);
        drive(x);
        @(negedge clk);
        drive(y);
        @(negedge clk);
        in_valid = 1'b0;
        check("flight out_valid", word_t'(out_valid), 64'd1);
        check("flight sum", sum, x.exp);
        check("flight reduced", reduced1 + reduced2, y.exp);
        rst_n = 1'b0;
        #1;
        check("midreset sum", sum, '0);
        check("midreset reduced1", reduced1, '0);
        check("midreset reduced2", reduced2, '0);
        check("midreset out_valid", word_t'(out_valid), '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("post-reset out_valid[%0d]", c), word_t'(out_valid), '0);
        end
        drive(z);
        @(negedge clk);
        in_valid = 1'b0;
        check("post-reset stage1 out_valid", word_t'(out_valid), '0);
        @(negedge clk);
        check("post-reset first out_valid", word_t'(out_valid), 64'd1);
        check("post-reset first sum", sum, z.exp);
        @(negedge clk);
        check("post-reset tail out_valid", word_t'(out_valid), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
